stp_frame_controller: RTL and testbench

// - Sequences serialToParallelWrapper (STP) to receive a block of N words from one serial line (SD-style DAT/CMD).
// - Flow: hunt start bit (0), run STP for N frames, check end bit (1), hand each word to downstream through a valid/ready register.
// - Sits between the host command FSM (start/abort/config) and the receive FIFO.

---
 rtl/stp_frame_controller_pkg.sv | 15 +
 rtl/stp_out_reg.sv | 35 +++
 rtl/stp_frame_controller.sv | 137 +++++++++++++
 tb/tb_stp_frame_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/stp_frame_controller_pkg.sv
// Shared state encodings and default widths for the STP block-receive controller.
package stp_frame_controller_pkg;

    localparam int DEF_WIDTH            = 8;
    localparam int DEF_FRAME_SIZE_WIDTH = 8;
    localparam int DEF_COUNT_WIDTH      = 10;
    localparam int DEF_TIMEOUT_WIDTH    = 16;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_RECEIVE    = 3'd2;
    localparam logic [2:0] ST_END_BIT    = 3'd3;
    localparam logic [2:0] ST_FLUSH      = 3'd4;

endpackage

// File: rtl/stp_out_reg.sv
// One-entry valid/ready holding register; ovf flags a load that finds it full and not draining.
module stp_out_reg
    import stp_frame_controller_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ovf
);

    assign ovf = load && valid && !ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load && !ovf) begin
            // a load into a draining entry keeps valid high with the new word
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stp_frame_controller.sv
// Sequences an external serial-to-parallel unit through start bit, N words and end bit,
// handing each word downstream through a one-entry valid/ready register.
module stp_frame_controller
    import stp_frame_controller_pkg::*;
#(
    parameter int WIDTH            = DEF_WIDTH,
    parameter int FRAME_SIZE_WIDTH = DEF_FRAME_SIZE_WIDTH,
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
    parameter int TIMEOUT_WIDTH    = DEF_TIMEOUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [FRAME_SIZE_WIDTH-1:0] framesize,
    input  logic [COUNT_WIDTH-1:0]      word_count,
    input  logic [TIMEOUT_WIDTH-1:0]    timeout,
    input  logic                        serial_in,
    output logic                        stp_enable,
    output logic [FRAME_SIZE_WIDTH-1:0] stp_framesize,
    input  logic                        stp_complete,
    input  logic [WIDTH-1:0]            stp_parallel,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err,
    output logic                        overflow_err,
    output logic                        end_err,
    output logic                        cfg_err
);

    logic [2:0]               state;
    logic [COUNT_WIDTH-1:0]   words_left;
    logic [TIMEOUT_WIDTH-1:0] to_q;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;
    logic                     cap;
    logic                     ovf;
    logic                     take;

    assign busy = (state != ST_IDLE);
    assign cap  = (state == ST_RECEIVE) && stp_complete;
    assign take = cap && !ovf;

    stp_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort && busy),
        .load      (cap),
        .load_data (stp_parallel),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .ovf       (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            stp_enable    <= 1'b0;
            stp_framesize <= '0;
            words_left    <= '0;
            to_q          <= '0;
            wait_cnt      <= '0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            overflow_err  <= 1'b0;
            end_err       <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && busy) begin
                // abort drops the block silently; error flags are left for the host to inspect
                state      <= ST_IDLE;
                stp_enable <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start && !abort) begin
                        stp_framesize <= framesize;
                        words_left    <= word_count;
                        to_q          <= timeout;
                        wait_cnt      <= '0;
                        timeout_err   <= 1'b0;
                        overflow_err  <= 1'b0;
                        end_err       <= 1'b0;
                        if (framesize == '0 || word_count == '0) begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            cfg_err <= 1'b0;
                            state   <= ST_WAIT_START;
                        end
                    end
                    ST_WAIT_START: begin
                        // start bit wins over a timeout expiring on the same cycle
                        if (!serial_in) begin
                            state      <= ST_RECEIVE;
                            stp_enable <= 1'b1;
                        end else if (to_q != '0 && wait_cnt >= to_q - TIMEOUT_WIDTH'(1)) begin
                            timeout_err <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_IDLE;
                        end else if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + TIMEOUT_WIDTH'(1);
                        end
                    end
                    ST_RECEIVE: begin
                        if (cap && ovf) begin
                            overflow_err <= 1'b1;
                            stp_enable   <= 1'b0;
                            state        <= ST_FLUSH;
                        end else if (take) begin
                            if (words_left != '0)
                                words_left <= words_left - COUNT_WIDTH'(1);
                            if (words_left <= COUNT_WIDTH'(1)) begin
                                stp_enable <= 1'b0;
                                state      <= ST_END_BIT;
                            end
                        end
                    end
                    ST_END_BIT: begin
                        if (!serial_in)
                            end_err <= 1'b1;
                        state <= ST_FLUSH;
                    end
                    ST_FLUSH: if (!out_valid) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stp_frame_controller.sv
// Randomized bench for stp_frame_controller: a behavioural serial-to-parallel unit feeds the DUT,
// and a cycle-indexed frame schedule plus handshake occupancy model predicts words and flags.
module tb_stp_frame_controller;

    localparam int W = 8, FSW = 8, CW = 10, TW = 16;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           start = 1'b0, abort = 1'b0, serial_in = 1'b1, out_ready = 1'b0;
    logic [FSW-1:0] framesize = '0;
    logic [CW-1:0]  word_count = '0;
    logic [TW-1:0]  timeout = '0;
    logic           stp_enable, stp_complete, out_valid, busy, done;
    logic           timeout_err, overflow_err, end_err, cfg_err;
    logic [FSW-1:0] stp_framesize;
    logic [W-1:0]   stp_parallel, out_data;

    int nvec = 0, nerr = 0;
    int fixed_words[$];

    logic           stp_clr = 1'b0;
    logic [FSW-1:0] stp_cnt;
    logic [W-1:0]   stp_sh;

    always #5 clk = ~clk;

    stp_frame_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .framesize(framesize), .word_count(word_count), .timeout(timeout),
        .serial_in(serial_in), .stp_enable(stp_enable), .stp_framesize(stp_framesize),
        .stp_complete(stp_complete), .stp_parallel(stp_parallel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .overflow_err(overflow_err), .end_err(end_err), .cfg_err(cfg_err)
    );

    // serial-to-parallel unit: MSB first, complete flagged while the last bit is on the line
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stp_cnt <= '0;
            stp_sh  <= '0;
        end else if (stp_clr) begin
            stp_cnt <= '0;
            stp_sh  <= '0;
        end else if (stp_enable) begin
            if (stp_complete) begin
                stp_cnt <= '0;
                stp_sh  <= '0;
            end else begin
                stp_cnt <= stp_cnt + 8'd1;
                stp_sh  <= {stp_sh[W-2:0], serial_in};
            end
        end
    end
    assign stp_complete = stp_enable && (stp_cnt == stp_framesize - 8'd1);
    assign stp_parallel = {stp_sh[W-2:0], serial_in};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_block(input int fs, input int wc, input int to, input int gap, input bit endb,
                             input int rdy_pct, input int rdy_force, input int abort_at,
                             input int spur_at, input int rst_at, input string tag);
        int words[$], sched[$], comp_t[$], exp_q[$], got[$];
        bit pend = 0, stopped, exp_ovf = 0, exp_to, hold_v = 0;
        logic [W-1:0] hold_d = '0;
        int k = 0, done_cnt = 0, done_t = -1, vmis = 0, stab = 0, en_seen = 0, limit, w;
        exp_to = (to != 0) && (to <= gap);
        for (int i = 0; i < wc; i++) begin
            w = (i < fixed_words.size()) ? fixed_words[i] : int'($urandom_range(0, 255));
            words.push_back(w & ((1 << fs) - 1));
        end
        for (int i = 0; i < gap; i++) sched.push_back(1);
        sched.push_back(0);
        for (int i = 0; i < wc; i++) begin
            for (int b = fs - 1; b >= 0; b--) sched.push_back((words[i] >> b) & 1);
            comp_t.push_back(sched.size());
        end
        sched.push_back(int'(endb));
        stopped = exp_to;
        limit = sched.size() + rdy_force + 60;

        start = 1'b1; framesize = FSW'(fs); word_count = CW'(wc); timeout = TW'(to);
        @(posedge clk); #1 start = 1'b0;
        for (int t = 1; t <= limit; t++) begin
            serial_in = (t <= sched.size()) ? (sched[t-1] != 0) : 1'b1;
            out_ready = (rdy_force > 0 && t >= rdy_force) || ($urandom_range(0, 99) < rdy_pct);
            abort = (t == abort_at);
            stp_clr = abort;
            start = (t == spur_at);
            if (start) framesize = FSW'(fs % 8 + 1);
            if (t == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk({tag, ":rst_flags"}, 32'({busy, out_valid, stp_enable, done, timeout_err,
                                              overflow_err, end_err, cfg_err}), 0);
                chk({tag, ":rst_data"}, 32'(out_data), 0);
                chk({tag, ":rst_fs"}, 32'(stp_framesize), 0);
                @(posedge clk); #1 rst_n = 1'b1;
                out_ready = 1'b0; serial_in = 1'b1;
                return;
            end
            @(negedge clk);
            if (stp_enable) en_seen++;
            if (out_valid !== pend) vmis++;
            if (hold_v && out_valid && out_data !== hold_d) stab++;
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) got.push_back(int'(out_data));
            if (done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (!stopped && k < wc && t == comp_t[k]) begin
                if (pend && !out_ready) begin
                    exp_ovf = 1;
                    stopped = 1;
                end else begin
                    exp_q.push_back(words[k]);
                    pend = 1;
                end
                k++;
            end else if (pend && out_ready) begin
                pend = 0;
            end
            if (t == abort_at) begin
                @(posedge clk); #1 abort = 1'b0; stp_clr = 1'b0; start = 1'b0;
                @(negedge clk);
                chk({tag, ":abort_idle"}, 32'({busy, out_valid, stp_enable}), 0);
                chk({tag, ":valid_track"}, vmis, 0);
                repeat (4) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                chk({tag, ":abort_no_done"}, done_cnt, 0);
                @(posedge clk); #1 out_ready = 1'b0; serial_in = 1'b1;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done_t >= 0 && t >= done_t + 3) break;
        end
        out_ready = 1'b0; serial_in = 1'b1;

        chk({tag, ":done_cnt"}, done_cnt, 1);
        chk({tag, ":nwords"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, ":word"}, got[i], exp_q[i]);
        chk({tag, ":ovf_err"}, 32'(overflow_err), 32'(exp_ovf));
        chk({tag, ":end_err"}, 32'(end_err), 32'(!exp_ovf && !exp_to && !endb));
        chk({tag, ":to_err"}, 32'(timeout_err), 32'(exp_to));
        chk({tag, ":cfg_err"}, 32'(cfg_err), 0);
        chk({tag, ":valid_track"}, vmis, 0);
        chk({tag, ":stable"}, stab, 0);
        chk({tag, ":idle"}, 32'(busy), 0);
        chk({tag, ":stp_fs"}, 32'(stp_framesize), fs);
        if (exp_to) begin
            chk({tag, ":to_time"}, done_t, to + 1);
            chk({tag, ":no_enable"}, en_seen, 0);
        end
        if (rdy_force > 0 && exp_ovf)
            chk({tag, ":done_after_ready"}, 32'(done_t > rdy_force), 1);
    endtask

    task automatic cfg_case(input int fs, input int wc, input string tag);
        start = 1'b1; framesize = FSW'(fs); word_count = CW'(wc); timeout = '0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk({tag, ":done"}, 32'(done), 1);
        chk({tag, ":cfg_err"}, 32'(cfg_err), 1);
        chk({tag, ":busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({tag, ":done_pulse"}, 32'(done), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs, wc, gap, to;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", 32'({busy, out_valid, stp_enable, done, timeout_err,
                                 overflow_err, end_err, cfg_err}), 0);
        chk("reset_data", 32'(out_data), 0);
        chk("reset_fs", 32'(stp_framesize), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        fixed_words = '{165, 60};
        run_block(8, 2, 100, 0, 1'b1, 100, 0, 0, 0, 0, "basic");
        fixed_words.delete();
        run_block(8, 1, 20, 100, 1'b1, 100, 0, 0, 0, 0, "timeout");
        run_block(8, 2, 0, 1, 1'b1, 0, 40, 0, 0, 0, "overflow");
        run_block(6, 3, 0, 2, 1'b0, 100, 0, 0, 0, 0, "end_bit");
        run_block(8, 3, 0, 1, 1'b1, 100, 0, 12, 0, 0, "abort");
        run_block(8, 3, 0, 1, 1'b1, 100, 0, 0, 0, 0, "post_abort");
        cfg_case(0, 3, "cfg_fs0");
        cfg_case(4, 0, "cfg_wc0");
        run_block(5, 2, 0, 0, 1'b1, 100, 0, 0, 4, 0, "busy_start");
        fixed_words = '{90};
        run_block(8, 3, 0, 1, 1'b1, 0, 0, 0, 0, 14, "reset_mid");
        fixed_words.delete();

        for (int n = 0; n < 12; n++) begin
            fs  = $urandom_range(1, 8);
            wc  = $urandom_range(1, 6);
            gap = $urandom_range(0, 4);
            to  = $urandom_range(0, 1) ? 0 : gap + 2 + int'($urandom_range(0, 50));
            run_block(fs, wc, to, gap, ($urandom_range(0, 3) != 0), $urandom_range(30, 100),
                      0, 0, 0, 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
